// File: rtl/rc4_key_search_ctrl_pkg.sv
// ============================================================================
// Module      : rc4_ctrl_pkg
// Description : Shared types and defaults for the RC4 key-search controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_ctrl_pkg;

    localparam int          KEY_W_DEF   = 24;
    localparam logic [23:0] KEY_MAX_DEF = 24'h3FFFFF;
    localparam int          ADDR_W_DEF  = 8;
    localparam int          DATA_W_DEF  = 8;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT_GO   = 4'd1,
        INIT_WAIT = 4'd2,
        SHUF_GO   = 4'd3,
        SHUF_WAIT = 4'd4,
        DEC_GO    = 4'd5,
        DEC_WAIT  = 4'd6,
        NEXT_KEY  = 4'd7,
        FOUND     = 4'd8,
        EXHAUSTED = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INIT = 2'd1,
        SEL_SHUF = 2'd2,
        SEL_DEC  = 2'd3
    } phase_sel_t;

    // The S memory owner is a pure function of the scheduler state.
    function automatic phase_sel_t phase_of(input state_t s);
        case (s)
            INIT_GO, INIT_WAIT: return SEL_INIT;
            SHUF_GO, SHUF_WAIT: return SEL_SHUF;
            DEC_GO,  DEC_WAIT:  return SEL_DEC;
            default:            return SEL_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_key_search_ctrl_if.sv
// ============================================================================
// Module      : rc4_key_search_ctrl_if
// Description : Control, engine handshake and S memory bundle of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rc4_key_search_ctrl_if #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              init_done;
    logic              shuf_done;
    logic              dec_done;
    logic              dec_fail;
    logic              init_start;
    logic              shuf_start;
    logic              dec_start;
    logic [KEY_W-1:0]  key;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_wdata;
    logic              init_wren;
    logic [ADDR_W-1:0] shuf_addr;
    logic [DATA_W-1:0] shuf_wdata;
    logic              shuf_wren;
    logic [ADDR_W-1:0] dec_addr;
    logic [DATA_W-1:0] dec_wdata;
    logic              dec_wren;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_wren;

    modport master (
        input  start, init_done, shuf_done, dec_done, dec_fail,
        input  init_addr, init_wdata, init_wren,
        input  shuf_addr, shuf_wdata, shuf_wren,
        input  dec_addr, dec_wdata, dec_wren,
        output init_start, shuf_start, dec_start,
        output key, busy, found, exhausted,
        output s_addr, s_wdata, s_wren
    );

    modport slave (
        output start, init_done, shuf_done, dec_done, dec_fail,
        output init_addr, init_wdata, init_wren,
        output shuf_addr, shuf_wdata, shuf_wren,
        output dec_addr, dec_wdata, dec_wren,
        input  init_start, shuf_start, dec_start,
        input  key, busy, found, exhausted,
        input  s_addr, s_wdata, s_wren
    );
endinterface

`default_nettype wire

// File: rtl/rc4_key_search_ctrl_s_mem_mux.sv
// ============================================================================
// Module      : s_mem_mux
// Description : Combinational 3:1 mux of engine requests onto the S memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_mem_mux
    import rc4_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  phase_sel_t        sel,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] shuf_addr,
    input  logic [DATA_W-1:0] shuf_wdata,
    input  logic              shuf_wren,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_wdata,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wren
);

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        case (sel)
            SEL_INIT: begin
                s_addr  = init_addr;
                s_wdata = init_wdata;
                s_wren  = init_wren;
            end
            SEL_SHUF: begin
                s_addr  = shuf_addr;
                s_wdata = shuf_wdata;
                s_wren  = shuf_wren;
            end
            SEL_DEC: begin
                s_addr  = dec_addr;
                s_wdata = dec_wdata;
                s_wren  = dec_wren;
            end
            default: begin
                s_addr  = '0;
                s_wdata = '0;
                s_wren  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rc4_key_search_ctrl.sv
// ============================================================================
// Module      : rc4_key_search_ctrl
// Description : Sequences init/shuffle/decrypt engines per candidate key and
//               owns the shared S memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_key_search_ctrl
    import rc4_ctrl_pkg::*;
#(
    parameter int               KEY_W   = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(KEY_MAX_DEF),
    parameter int               ADDR_W  = ADDR_W_DEF,
    parameter int               DATA_W  = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    rc4_key_search_ctrl_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_key;
    logic             r_found;
    logic             r_exhausted;
    logic             w_init_start;
    logic             w_shuf_start;
    logic             w_dec_start;
    logic             w_busy;
    logic             w_accept;
    logic             w_at_max;
    phase_sel_t       w_sel;

    assign w_at_max = (r_key == KEY_MAX);
    assign w_accept = !w_busy && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_init_start = 1'b0;
        w_shuf_start = 1'b0;
        w_dec_start  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE, FOUND, EXHAUSTED: begin
                w_busy = 1'b0;
                if (bus.start) w_next = INIT_GO;
            end
            INIT_GO: begin
                w_init_start = 1'b1;
                w_next       = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (bus.init_done) w_next = SHUF_GO;
            end
            SHUF_GO: begin
                w_shuf_start = 1'b1;
                w_next       = SHUF_WAIT;
            end
            SHUF_WAIT: begin
                if (bus.shuf_done) w_next = DEC_GO;
            end
            DEC_GO: begin
                w_dec_start = 1'b1;
                w_next      = DEC_WAIT;
            end
            DEC_WAIT: begin
                if (bus.dec_done) w_next = bus.dec_fail ? NEXT_KEY : FOUND;
            end
            NEXT_KEY: begin
                w_next = w_at_max ? EXHAUSTED : INIT_GO;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Key and result flags; the key never advances past KEY_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key       <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else if (w_accept) begin
            r_key       <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            if (r_state == DEC_WAIT && bus.dec_done && !bus.dec_fail) begin
                r_found <= 1'b1;
            end
            if (r_state == NEXT_KEY) begin
                if (w_at_max) begin
                    r_exhausted <= 1'b1;
                end else begin
                    r_key <= r_key + 1'b1;
                end
            end
        end
    end

    assign w_sel          = phase_of(r_state);
    assign bus.init_start = w_init_start;
    assign bus.shuf_start = w_shuf_start;
    assign bus.dec_start  = w_dec_start;
    assign bus.busy       = w_busy;
    assign bus.key        = r_key;
    assign bus.found      = r_found;
    assign bus.exhausted  = r_exhausted;

    s_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_s_mem_mux (
        .sel        (w_sel),
        .init_addr  (bus.init_addr),
        .init_wdata (bus.init_wdata),
        .init_wren  (bus.init_wren),
        .shuf_addr  (bus.shuf_addr),
        .shuf_wdata (bus.shuf_wdata),
        .shuf_wren  (bus.shuf_wren),
        .dec_addr   (bus.dec_addr),
        .dec_wdata  (bus.dec_wdata),
        .dec_wren   (bus.dec_wren),
        .s_addr     (bus.s_addr),
        .s_wdata    (bus.s_wdata),
        .s_wren     (bus.s_wren)
    );

endmodule

`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
// ============================================================================
// Module      : tb_rc4_key_search_ctrl
// Description : Directed bench for the RC4 key-search scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_key_search_ctrl;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    rc4_key_search_ctrl_if #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) bus_a ();
    rc4_key_search_ctrl_if #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) bus_b ();

    rc4_key_search_ctrl #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rc4_key_search_ctrl #(.KEY_W(24), .KEY_MAX(24'd3), .ADDR_W(8), .DATA_W(8)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Engine models: each done drops on its start pulse and rises 3 cycles later.
    int fail_until = 0;
    int cnt_i, cnt_s, cnt_d;
    int n_init = 0, n_shuf = 0, n_dec = 0, order_errs = 0, last_ph = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus_a.init_done = 1'b0; bus_a.shuf_done = 1'b0;
            bus_a.dec_done  = 1'b0; bus_a.dec_fail  = 1'b0;
            cnt_i = 0; cnt_s = 0; cnt_d = 0; last_ph = 0;
        end else begin
            if (bus_a.init_start) begin
                bus_a.init_done = 1'b0; cnt_i = 3; n_init++;
                if (last_ph == 1 || last_ph == 2) order_errs++;
                last_ph = 1;
            end else if (cnt_i > 0) begin
                cnt_i--;
                if (cnt_i == 0) bus_a.init_done = 1'b1;
            end
            if (bus_a.shuf_start) begin
                bus_a.shuf_done = 1'b0; cnt_s = 3; n_shuf++;
                if (last_ph != 1) order_errs++;
                last_ph = 2;
            end else if (cnt_s > 0) begin
                cnt_s--;
                if (cnt_s == 0) bus_a.shuf_done = 1'b1;
            end
            if (bus_a.dec_start) begin
                bus_a.dec_done = 1'b0; cnt_d = 3; n_dec++;
                if (last_ph != 2) order_errs++;
                last_ph = 3;
            end else if (cnt_d > 0) begin
                cnt_d--;
                if (cnt_d == 0) begin
                    bus_a.dec_done = 1'b1;
                    bus_a.dec_fail = (32'(bus_a.key) < fail_until);
                end
            end
        end
    end

    int cb_i, cb_s, cb_d;
    int nb_init = 0, nb_dec = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus_b.init_done = 1'b0; bus_b.shuf_done = 1'b0;
            bus_b.dec_done  = 1'b0; bus_b.dec_fail  = 1'b1;
            cb_i = 0; cb_s = 0; cb_d = 0;
        end else begin
            if (bus_b.init_start) begin
                bus_b.init_done = 1'b0; cb_i = 2; nb_init++;
            end else if (cb_i > 0) begin
                cb_i--;
                if (cb_i == 0) bus_b.init_done = 1'b1;
            end
            if (bus_b.shuf_start) begin
                bus_b.shuf_done = 1'b0; cb_s = 2;
            end else if (cb_s > 0) begin
                cb_s--;
                if (cb_s == 0) bus_b.shuf_done = 1'b1;
            end
            if (bus_b.dec_start) begin
                bus_b.dec_done = 1'b0; cb_d = 2; nb_dec++;
            end else if (cb_d > 0) begin
                cb_d--;
                if (cb_d == 0) bus_b.dec_done = 1'b1;
            end
        end
    end

    // S memory routing monitor, sampled mid-cycle away from both edges.
    logic route_en = 1'b0;
    int   ph = 0;
    logic [7:0] e_addr, e_data;
    logic       e_wren;

    always @(negedge clk) begin
        if (rst) bus_a.init_wren = 1'b0;
        else if (route_en) bus_a.init_wren = ~bus_a.init_wren;
    end

    always @(posedge clk) begin
        #2;
        if (route_en) begin
            if (bus_a.init_start) ph = 1;
            else if (bus_a.shuf_start) ph = 2;
            else if (bus_a.dec_start) ph = 3;
            else if (ph == 3 && bus_a.dec_done) ph = 0;
            case (ph)
                1:       begin e_addr = 8'h11; e_data = 8'hEE; e_wren = bus_a.init_wren; end
                2:       begin e_addr = 8'h22; e_data = 8'hDD; e_wren = 1'b1; end
                3:       begin e_addr = 8'h33; e_data = 8'hCC; e_wren = 1'b0; end
                default: begin e_addr = 8'h00; e_data = 8'h00; e_wren = 1'b0; end
            endcase
            check("route_addr",  bus_a.s_addr,  e_addr);
            check("route_wdata", bus_a.s_wdata, e_data);
            check("route_wren",  bus_a.s_wren,  e_wren);
        end else begin
            ph = 0;
        end
    end

    task automatic pulse_start_a();
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
    endtask

    task automatic wait_a(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_a.found || bus_a.exhausted) && n < budget);
        if (!(bus_a.found || bus_a.exhausted)) check("timeout_a", 32'd0, 32'd1);
    endtask

    int b_init, b_shuf, b_dec, seen, n;

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_a.init_addr = 8'h11; bus_a.init_wdata = 8'hEE;
        bus_a.shuf_addr = 8'h22; bus_a.shuf_wdata = 8'hDD; bus_a.shuf_wren = 1'b1;
        bus_a.dec_addr  = 8'h33; bus_a.dec_wdata  = 8'hCC; bus_a.dec_wren  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.init_addr = 8'h0; bus_b.init_wdata = 8'h0; bus_b.init_wren = 1'b0;
        bus_b.shuf_addr = 8'h0; bus_b.shuf_wdata = 8'h0; bus_b.shuf_wren = 1'b0;
        bus_b.dec_addr  = 8'h0; bus_b.dec_wdata  = 8'h0; bus_b.dec_wren  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_key",   bus_a.key, 0);
        check("rst_busy",  bus_a.busy, 0);
        check("rst_flags", {bus_a.found, bus_a.exhausted}, 0);
        check("rst_starts", {bus_a.init_start, bus_a.shuf_start, bus_a.dec_start}, 0);
        check("rst_s_port", {bus_a.s_addr, bus_a.s_wdata, bus_a.s_wren}, 0);
        rst = 1'b0;

        // First key decrypts cleanly.
        fail_until = 0;
        b_init = n_init; b_shuf = n_shuf; b_dec = n_dec;
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk);
        check("go_init_start", bus_a.init_start, 1);
        check("go_busy", bus_a.busy, 1);
        bus_a.start = 1'b0;
        @(negedge clk);
        check("go_init_pulse_len", bus_a.init_start, 0);
        wait_a(500);
        check("k0_found", bus_a.found, 1);
        check("k0_key", bus_a.key, 0);
        check("k0_busy", bus_a.busy, 0);
        check("k0_exh", bus_a.exhausted, 0);
        check("k0_pulses", {8'(n_init - b_init), 8'(n_shuf - b_shuf), 8'(n_dec - b_dec)}, 32'h010101);
        check("k0_order", order_errs, 0);

        // Keys 0..4 fail, key 5 succeeds.
        fail_until = 5;
        b_init = n_init; b_dec = n_dec;
        pulse_start_a();
        wait_a(2000);
        check("k5_found", bus_a.found, 1);
        check("k5_key", bus_a.key, 5);
        check("k5_dec_pulses", n_dec - b_dec, 6);
        check("k5_init_pulses", n_init - b_init, 6);
        check("k5_order", order_errs, 0);

        // start during SHUF_WAIT with init_done still high must be ignored.
        fail_until = 2;
        b_init = n_init; b_shuf = n_shuf; b_dec = n_dec;
        pulse_start_a();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.shuf_start && n < 100);
        check("sw_reached_shuf", bus_a.shuf_start, 1);
        @(negedge clk);
        check("sw_init_done_high", bus_a.init_done, 1);
        bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
        check("sw_no_restart", bus_a.init_start, 0);
        check("sw_still_busy", bus_a.busy, 1);
        wait_a(2000);
        check("sw_found", bus_a.found, 1);
        check("sw_key", bus_a.key, 2);
        check("sw_pulses", {8'(n_init - b_init), 8'(n_shuf - b_shuf), 8'(n_dec - b_dec)}, 32'h030303);
        check("sw_order", order_errs, 0);

        // Address/data/write-enable routing through two keys.
        fail_until = 1;
        route_en = 1'b1;
        pulse_start_a();
        wait_a(1000);
        @(negedge clk);
        route_en = 1'b0;
        check("rt_key", bus_a.key, 1);

        // Reset in the middle of DEC_WAIT for key 1.
        fail_until = 100;
        pulse_start_a();
        seen = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (bus_a.dec_start) seen++;
        end while (seen < 2 && n < 200);
        check("mr_second_dec", seen, 2);
        bus_a.dec_wren = 1'b1;
        @(negedge clk);
        check("mr_pre_wren", bus_a.s_wren, 1);
        check("mr_pre_key", bus_a.key, 1);
        #2 rst = 1'b1;
        #1;
        check("mr_s_wren", bus_a.s_wren, 0);
        check("mr_s_addr", bus_a.s_addr, 0);
        check("mr_busy", bus_a.busy, 0);
        check("mr_key", bus_a.key, 0);
        check("mr_flags", {bus_a.found, bus_a.exhausted}, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        bus_a.dec_wren = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_stays_idle", bus_a.busy, 0);

        // Small key space, every key fails.
        b_init = nb_init; b_dec = nb_dec;
        @(negedge clk) bus_b.start = 1'b1;
        @(negedge clk) bus_b.start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_b.exhausted && n < 1000);
        check("ex_exhausted", bus_b.exhausted, 1);
        check("ex_key", bus_b.key, 3);
        check("ex_found", bus_b.found, 0);
        check("ex_busy", bus_b.busy, 0);
        check("ex_dec_pulses", nb_dec - b_dec, 4);
        check("ex_init_pulses", nb_init - b_init, 4);
        repeat (4) @(negedge clk);
        check("ex_key_holds", bus_b.key, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
